rcv_tick: RTL and testbench
===========================

RCV_TICK -- requirements
Module: rcv_tick

Interface
REQ-001 Parameter CNT_W, default 8, width of the tick count and accumulator (legal 2..16).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_in (legal 2..4).
REQ-003 clk  input  1  sole clock; all flops rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tick_in  input  1  asynchronous level line from the tick sender; each 0->1 transition is one tick.
REQ-006 tick_pulse  output  1  registered single-cycle strobe per detected tick.
REQ-007 count_valid  output  1  count_data holds an unconsumed count.
REQ-008 count_data  output  CNT_W  number of ticks since the previous transfer.
REQ-009 count_ready  input  1  consumer accepts count_data when count_valid is also high.
REQ-010 ovf  output  1  sticky flag: at least one tick was lost to saturation.
REQ-011 ovf_clr  input  1  single-cycle clear of ovf.

Function
REQ-012 tick_in shall pass through a SYNC_STAGES-deep flop chain; s_out is the last stage, prev is s_out delayed one cycle.
REQ-013 tick_pulse shall be registered from (s_out AND NOT prev), with no combinational path from tick_in.
REQ-014 Latency: tick_in first sampled high at edge E0 -> tick_pulse high for exactly one cycle after edge E0+SYNC_STAGES.
REQ-015 tick_in high and low phases of at least 2 clk periods each shall each yield exactly one tick; shorter phases are not guaranteed to be detected.
REQ-016 The FSM shall have two states: IDLE (count_valid=0) and HOLD (count_valid=1).
REQ-017 IDLE with tick_pulse=1 -> next cycle count_data=1, count_valid=1, state HOLD.
REQ-018 HOLD without a transfer -> count_data stable; each tick_pulse increments the internal accumulator acc.
REQ-019 HOLD with transfer (count_ready=1) and (acc + tick_pulse) > 0 -> count_data <= acc + tick_pulse, acc <= 0, state stays HOLD.
REQ-020 HOLD with transfer and (acc + tick_pulse) == 0 -> count_valid <= 0, state IDLE.
REQ-021 A tick coincident with a transfer shall be counted in the newly loaded count_data, never lost and never double-counted.
REQ-022 acc and loaded count_data shall saturate at 2^CNT_W-1; a tick arriving while saturated shall set ovf and leave the value at max.
REQ-023 ovf shall clear on ovf_clr; if a set event and ovf_clr occur in the same cycle, set wins.
REQ-024 count_ready while count_valid=0 shall be ignored.
REQ-025 Sum of all transferred count_data plus acc shall equal total detected ticks whenever ovf=0.

Reset
REQ-026 rst_n low shall asynchronously clear the sync chain, prev, acc, count_data, tick_pulse, count_valid, and ovf to 0, and set the state to IDLE.
REQ-027 Reset release shall be synchronous to clk; the first FSM update shall occur on the first rising edge with rst_n high.
REQ-028 Reset mid-operation shall discard the pending count and acc with no transfer.
REQ-029 tick_in already high at reset release shall be counted as one tick, because the chain resets to 0.

Verification
REQ-030 Single tick, SYNC_STAGES=2 -> tick_pulse 2 edges after first sample, count_valid next cycle, count_data=1; count_ready=1 -> count_valid=0.
REQ-031 5 ticks with count_ready held 0 -> count_data=1, then acc=4; count_ready pulse -> count_data=4, valid stays 1; second pulse -> IDLE.
REQ-032 Tick coincident with the count_ready transfer cycle, acc=2 -> new count_data=3, acc=0.
REQ-033 CNT_W=2, 6 ticks with no ready -> count_data=1, acc saturates at 3, ovf=1; ovf_clr together with a further tick -> ovf stays 1; ovf_clr alone -> ovf=0.
REQ-034 rst_n low in HOLD with acc=2 -> all outputs 0 immediately; tick_in held high across release -> exactly one tick, count_data=1.
REQ-035 1-cycle tick_in glitches plus 2-cycle-minimum random traffic and random count_ready -> scoreboard satisfies REQ-025 and no count is lost.

Source files
------------

// File: rtl/rcv_tick.sv
// rtl/rcv_tick.sv - asynchronous tick receiver with saturating count handoff
module rcv_tick #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    output logic             tick_pulse,
    output logic             count_valid,
    output logic [CNT_W-1:0] count_data,
    input  logic             count_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    state_t                 state_q;
    logic                   valid_q;
    logic [CNT_W-1:0]       data_q;
    logic [CNT_W-1:0]       acc_q;
    logic                   ovf_q;

    logic [CNT_W:0]         acc_sum;
    logic [CNT_W-1:0]       acc_d;
    logic                   acc_full;
    logic                   ovf_set;
    logic                   ovf_d;

    // Synchronizer chain, delayed copy of its output, and registered rising-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Saturating acc + pulse; a tick landing on a full accumulator is the only loss case
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {{CNT_W{1'b0}}, pulse_q};
        acc_full = (acc_q == CNT_MAX);
        acc_d    = acc_sum[CNT_W] ? CNT_MAX : acc_sum[CNT_W-1:0];
        ovf_set  = (state_q == HOLD) && pulse_q && acc_full;
        ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    end

    // Count handoff FSM: IDLE waits for the first tick, HOLD presents a count and accumulates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            case (state_q)
                IDLE: begin
                    // count_ready is ignored here: nothing is being offered
                    if (pulse_q) begin
                        data_q  <= CNT_ONE;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (count_ready) begin
                        // Coincident tick folds into the freshly loaded count
                        if (acc_q != '0 || pulse_q) begin
                            data_q <= acc_d;
                            acc_q  <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        acc_q <= acc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick_pulse  = pulse_q;
    assign count_valid = valid_q;
    assign count_data  = data_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_rcv_tick.sv
// tb/tb_rcv_tick.sv - directed and scoreboarded bench for rcv_tick
module tb_rcv_tick;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       count_ready;
    logic       ovf_clr;

    logic       a_pulse, a_valid, a_ovf;
    logic [7:0] a_data;
    logic       b_pulse, b_valid, b_ovf;
    logic [1:0] b_data;

    int n_chk = 0;
    int n_err = 0;

    int exp_ticks   = 0;
    int seen_pulses = 0;
    int sum_xfer    = 0;

    always #5 clk = ~clk;

    rcv_tick #(.CNT_W(8), .SYNC_STAGES(2)) u_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .tick_pulse  (a_pulse),
        .count_valid (a_valid),
        .count_data  (a_data),
        .count_ready (count_ready),
        .ovf         (a_ovf),
        .ovf_clr     (ovf_clr)
    );

    rcv_tick #(.CNT_W(2), .SYNC_STAGES(2)) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .tick_pulse  (b_pulse),
        .count_valid (b_valid),
        .count_data  (b_data),
        .count_ready (count_ready),
        .ovf         (b_ovf),
        .ovf_clr     (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 2 cycles high, 2 cycles low; the strobe and FSM update land inside the low phase
    task automatic tick_once();
        tick_in = 1'b1;
        nclk(2);
        tick_in = 1'b0;
        nclk(2);
    endtask

    task automatic ready_pulse();
        count_ready = 1'b1;
        nclk(1);
        count_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nclk(2);
        rst_n = 1'b1;
        nclk(1);
    endtask

    task automatic step(input logic tin, input logic rdy, input logic glitch);
        @(negedge clk);
        tick_in     = tin;
        count_ready = rdy;
        #1;
        if (a_pulse) seen_pulses++;
        if (a_valid && count_ready) sum_xfer += int'(a_data);
        // Sub-cycle glitch that returns low before the next rising edge
        if (glitch) begin
            tick_in = 1'b1;
            #2;
            tick_in = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  phase_left;
        logic cur;

        rst_n       = 1'b0;
        tick_in     = 1'b0;
        count_ready = 1'b0;
        ovf_clr     = 1'b0;
        nclk(2);
        chk("rst_pulse", a_pulse, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data",  a_data,  0);
        chk("rst_ovf",   a_ovf,   0);
        rst_n = 1'b1;
        nclk(2);

        // Single tick latency and handoff
        tick_in = 1'b1;
        nclk(1);
        chk("lat_e0_pulse", a_pulse, 0);
        nclk(1);
        chk("lat_e1_pulse", a_pulse, 0);
        tick_in = 1'b0;
        nclk(1);
        chk("lat_e2_pulse", a_pulse, 1);
        chk("lat_e2_valid", a_valid, 0);
        nclk(1);
        chk("lat_e3_pulse", a_pulse, 0);
        chk("lat_e3_valid", a_valid, 1);
        chk("lat_e3_data",  a_data,  1);
        ready_pulse();
        chk("single_xfer_idle", a_valid, 0);

        // Five ticks without ready, then two transfers
        repeat (5) tick_once();
        chk("five_data",  a_data,  1);
        chk("five_valid", a_valid, 1);
        ready_pulse();
        chk("five_xfer1_data",  a_data,  4);
        chk("five_xfer1_valid", a_valid, 1);
        ready_pulse();
        chk("five_xfer2_idle", a_valid, 0);

        // Tick coincident with the transfer cycle while acc=2
        repeat (3) tick_once();
        tick_in = 1'b1;
        nclk(2);
        tick_in = 1'b0;
        nclk(1);
        chk("coin_pulse", a_pulse, 1);
        count_ready = 1'b1;
        nclk(1);
        count_ready = 1'b0;
        chk("coin_data",  a_data,  3);
        chk("coin_valid", a_valid, 1);
        ready_pulse();
        chk("coin_acc_zero", a_valid, 0);

        // Reset in HOLD with acc=2, tick_in high across release
        repeat (3) tick_once();
        chk("rstmid_pre_valid", a_valid, 1);
        tick_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_pulse", a_pulse, 0);
        chk("rstmid_valid", a_valid, 0);
        chk("rstmid_data",  a_data,  0);
        chk("rstmid_ovf",   a_ovf,   0);
        nclk(2);
        rst_n = 1'b1;
        nclk(5);
        chk("rel_valid", a_valid, 1);
        chk("rel_data",  a_data,  1);
        nclk(4);
        ready_pulse();
        chk("rel_one_tick", a_valid, 0);
        tick_in = 1'b0;
        nclk(3);

        // Saturation and sticky overflow on the 2-bit instance
        do_reset();
        repeat (4) tick_once();
        chk("sat4_data", b_data, 1);
        chk("sat4_ovf",  b_ovf,  0);
        tick_once();
        chk("sat5_ovf", b_ovf, 1);
        tick_once();
        chk("sat6_ovf",   b_ovf,   1);
        chk("sat6_data",  b_data,  1);
        chk("sat6_valid", b_valid, 1);
        tick_in = 1'b1;
        nclk(2);
        tick_in = 1'b0;
        nclk(1);
        chk("clr_tick_pulse", b_pulse, 1);
        ovf_clr = 1'b1;
        nclk(1);
        ovf_clr = 1'b0;
        chk("clr_set_wins", b_ovf, 1);
        ovf_clr = 1'b1;
        nclk(1);
        ovf_clr = 1'b0;
        chk("clr_alone", b_ovf, 0);
        ready_pulse();
        chk("sat_xfer_data", b_data, 3);
        ready_pulse();
        chk("sat_xfer_idle", b_valid, 0);

        // Random 2..5-cycle phases with sub-cycle glitches and random ready
        do_reset();
        phase_left = 0;
        cur        = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (phase_left == 0) begin
                cur        = ~cur;
                phase_left = int'($urandom_range(2, 5));
                if (cur) exp_ticks++;
            end
            phase_left--;
            step(cur, 1'($urandom_range(0, 1)), (!cur) && ($urandom_range(0, 3) == 0));
        end
        repeat (12) step(1'b0, 1'b1, 1'b0);
        chk("rand_pulses", seen_pulses, exp_ticks);
        chk("rand_sum",    sum_xfer,    exp_ticks);
        chk("rand_drained", a_valid, 0);
        chk("rand_ovf",     a_ovf,   0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
